// File: rtl/ula_execucao.sv
// Execute stage for the 8-register bank: ALU ops in one cycle, one-cycle write pulse, N/C/Z flags.
// Define ULA_MUL_EN to make op 111 an iterative shift-add MUL; otherwise op 111 is MOV.
module ula_execucao #(
  parameter int LARGURA   = 8,
  parameter int NREG_BITS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valido,
  output logic                 in_pronto,
  input  logic [2:0]           op,
  input  logic [LARGURA-1:0]   dado_a,
  input  logic [LARGURA-1:0]   dado_b,
  input  logic [NREG_BITS-1:0] reg_dest,
  output logic [LARGURA-1:0]   esc_dado,
  output logic [NREG_BITS-1:0] reg_esc,
  output logic                 escrita,
  output logic [2:0]           flags,
  output logic                 ocupado
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

`ifdef ULA_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CNT_W  = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {OCIOSO = 2'b00, MULT = 2'b01, ESCREVE = 2'b10} estado_t;
`else
  typedef enum logic [1:0] {OCIOSO = 2'b00, ESCREVE = 2'b10} estado_t;
`endif

  // Returns {carry, result}; op 111 falls to the MOV default.
  function automatic logic [LARGURA:0] alu_calc(input logic [2:0] op_f,
                                                input logic [LARGURA-1:0] a_f,
                                                input logic [LARGURA-1:0] b_f);
    logic [LARGURA:0] wide_v;
    logic [LARGURA:0] shr_v;
    logic [2:0]       amt_v;
    amt_v  = b_f[2:0];
    wide_v = {(LARGURA+1){1'b0}};
    shr_v  = {(LARGURA+1){1'b0}};
    case (op_f)
      OP_ADD: wide_v = {1'b0, a_f} + {1'b0, b_f};
      OP_SUB: begin
        wide_v[LARGURA-1:0] = a_f - b_f;
        wide_v[LARGURA]     = (a_f < b_f);
      end
      OP_AND: wide_v = {1'b0, a_f & b_f};
      OP_OR:  wide_v = {1'b0, a_f | b_f};
      OP_XOR: wide_v = {1'b0, a_f ^ b_f};
      // The last bit shifted out lands in the guard bit; a zero shift leaves it clear.
      OP_SHL: wide_v = {1'b0, a_f} << amt_v;
      OP_SHR: begin
        shr_v  = {a_f, 1'b0} >> amt_v;
        wide_v = {shr_v[0], shr_v[LARGURA:1]};
      end
      default: wide_v = {1'b0, a_f};
    endcase
    return wide_v;
  endfunction

  function automatic logic [2:0] make_flags(input logic [LARGURA-1:0] res_f, input logic c_f);
    return {res_f[LARGURA-1], c_f, (res_f == {LARGURA{1'b0}})};
  endfunction

  estado_t                state_r;
  logic [LARGURA-1:0]     esc_dado_r;
  logic [NREG_BITS-1:0]   reg_esc_r;
  logic                   escrita_r;
  logic [2:0]             flags_r;
  logic [LARGURA:0]       alu_s;

`ifdef ULA_MUL_EN
  logic [CNT_W-1:0]       cnt_r;
  logic [2*LARGURA-1:0]   acc_r;
  logic [2*LARGURA-1:0]   mcand_r;
  logic [LARGURA-1:0]     mplier_r;
  logic [NREG_BITS-1:0]   dest_r;
  logic [2*LARGURA-1:0]   acc_nxt_s;

  // Next partial product of the shift-add multiplier.
  always_comb begin
    acc_nxt_s = acc_r;
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end
`endif

  // Single-cycle ALU result on the live inputs, used at the accept edge.
  always_comb begin
    alu_s = alu_calc(op, dado_a, dado_b);
  end

  // Stage FSM with result, index, write pulse and flags registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= OCIOSO;
      esc_dado_r <= {LARGURA{1'b0}};
      reg_esc_r  <= {NREG_BITS{1'b0}};
      escrita_r  <= 1'b0;
      flags_r    <= 3'b000;
`ifdef ULA_MUL_EN
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*LARGURA){1'b0}};
      mcand_r    <= {(2*LARGURA){1'b0}};
      mplier_r   <= {LARGURA{1'b0}};
      dest_r     <= {NREG_BITS{1'b0}};
`endif
    end else begin
      escrita_r <= 1'b0;
      case (state_r)
        OCIOSO: begin
          if (in_valido) begin
`ifdef ULA_MUL_EN
            if (op == OP_MUL) begin
              state_r  <= MULT;
              cnt_r    <= CNT_W'(LARGURA);
              acc_r    <= {(2*LARGURA){1'b0}};
              mcand_r  <= {{LARGURA{1'b0}}, dado_a};
              mplier_r <= dado_b;
              dest_r   <= reg_dest;
            end else
`endif
            begin
              esc_dado_r <= alu_s[LARGURA-1:0];
              reg_esc_r  <= reg_dest;
              flags_r    <= make_flags(alu_s[LARGURA-1:0], alu_s[LARGURA]);
              escrita_r  <= 1'b1;
              state_r    <= ESCREVE;
            end
          end
        end
`ifdef ULA_MUL_EN
        MULT: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= {mcand_r[2*LARGURA-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[LARGURA-1:1]};
          cnt_r    <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            esc_dado_r <= acc_nxt_s[LARGURA-1:0];
            reg_esc_r  <= dest_r;
            flags_r    <= make_flags(acc_nxt_s[LARGURA-1:0], |acc_nxt_s[2*LARGURA-1:LARGURA]);
            escrita_r  <= 1'b1;
            state_r    <= ESCREVE;
          end
        end
`endif
        ESCREVE: state_r <= OCIOSO;
        default: state_r <= OCIOSO;
      endcase
    end
  end

  assign in_pronto = (state_r == OCIOSO);
  assign ocupado   = (state_r != OCIOSO);
  assign esc_dado  = esc_dado_r;
  assign reg_esc   = reg_esc_r;
  assign escrita   = escrita_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_ula_execucao.sv
// Scoreboard bench for ula_execucao; MUL or MOV scenarios follow ULA_MUL_EN.
module tb_ula_execucao;

  logic       clock;
  logic       reset;
  logic       in_valido;
  logic       in_pronto;
  logic [2:0] op;
  logic [7:0] dado_a;
  logic [7:0] dado_b;
  logic [2:0] reg_dest;
  logic [7:0] esc_dado;
  logic [2:0] reg_esc;
  logic       escrita;
  logic [2:0] flags;
  logic       ocupado;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  logic [13:0] sb_q[$];

  ula_execucao #(.LARGURA(8), .NREG_BITS(3)) dut (
    .clock(clock), .reset(reset), .in_valido(in_valido), .in_pronto(in_pronto),
    .op(op), .dado_a(dado_a), .dado_b(dado_b), .reg_dest(reg_dest),
    .esc_dado(esc_dado), .reg_esc(reg_esc), .escrita(escrita), .flags(flags),
    .ocupado(ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: returns {dest, result, N, C, Z}.
  function automatic logic [13:0] model(input logic [2:0] o, input logic [7:0] a,
                                        input logic [7:0] b, input logic [2:0] d);
    int unsigned p;
    int unsigned sh;
    logic [7:0] r;
    logic c;
    sh = 32'(b[2:0]);
    p = 32'd0;
    r = 8'h00;
    c = 1'b0;
    case (o)
      3'd0: begin p = 32'(a) + 32'(b); r = p[7:0]; c = p[8]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin p = 32'(a) << sh; r = p[7:0]; c = (sh != 0) ? p[8] : 1'b0; end
      3'd6: begin
        r = a >> sh;
        if (sh != 0) c = a[sh-1];
        else c = 1'b0;
      end
      default: begin
`ifdef ULA_MUL_EN
        p = 32'(a) * 32'(b); r = p[7:0]; c = (p[15:8] != 8'h00);
`else
        r = a; c = 1'b0;
`endif
      end
    endcase
    return {d, r, r[7], c, (r == 8'h00)};
  endfunction

  // Scoreboard: every write pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (escrita === 1'b1) begin
      logic [13:0] exp_v;
      writes++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got reg=%0d dado=%02h flags=%03b with nothing pending",
                 reg_esc, esc_dado, flags);
      end else begin
        exp_v = sb_q.pop_front();
        if ({reg_esc, esc_dado, flags} !== exp_v) begin
          failures++;
          $display("FAIL write_data got reg=%0d dado=%02h flags=%03b expected reg=%0d dado=%02h flags=%03b",
                   reg_esc, esc_dado, flags, exp_v[13:11], exp_v[10:3], exp_v[2:0]);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; in_valido = 1'b0; op = 3'd0; dado_a = 8'h00; dado_b = 8'h00; reg_dest = 3'd0;
    repeat (2) @(negedge clock);
    checks++; if (esc_dado !== 8'h00) begin failures++; $display("FAIL reset_esc_dado got %02h expected 00", esc_dado); end
    checks++; if (reg_esc !== 3'd0) begin failures++; $display("FAIL reset_reg_esc got %0d expected 0", reg_esc); end
    checks++; if (escrita !== 1'b0) begin failures++; $display("FAIL reset_escrita got %b expected 0", escrita); end
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got %03b expected 000", flags); end
    checks++; if (in_pronto !== 1'b1) begin failures++; $display("FAIL reset_in_pronto got %b expected 1", in_pronto); end
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado got %b expected 0", ocupado); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Issues one op from idle and checks write latency, busy cycles and the return to idle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] d, input int lat);
    int n;
    int low;
    @(negedge clock);
    checks++; if (in_pronto !== 1'b1) begin failures++; $display("FAIL %s_ready got %b expected 1", name, in_pronto); end
    op = o; dado_a = a; dado_b = b; reg_dest = d; in_valido = 1'b1;
    sb_q.push_back(model(o, a, b, d));
    @(posedge clock);
    #1;
    in_valido = 1'b0; dado_a = ~a; dado_b = ~b; reg_dest = ~d;
    n = 0; low = 0;
    do begin
      @(negedge clock);
      n++;
      if (!in_pronto && ocupado) low++;
    end while (escrita !== 1'b1 && n < 40);
    checks++; if (n != lat) begin failures++; $display("FAIL %s_latency got %0d expected %0d", name, n, lat); end
    checks++; if (low != lat) begin failures++; $display("FAIL %s_busy_cycles got %0d expected %0d", name, low, lat); end
    @(negedge clock);
    checks++; if (escrita !== 1'b0 || in_pronto !== 1'b1) begin
      failures++; $display("FAIL %s_pulse_end got escrita=%b in_pronto=%b expected 0 1", name, escrita, in_pronto);
    end
  endtask

  task automatic test_alu();
    run_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 3'd3, 1);
    run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 3'd1, 1);
    run_op("sub_05_07", 3'd1, 8'h05, 8'h07, 3'd2, 1);
    run_op("shl_81_1", 3'd5, 8'h81, 8'h01, 3'd4, 1);
    run_op("shl_by_0", 3'd5, 8'h81, 8'h08, 3'd5, 1);
    run_op("shr_81_1", 3'd6, 8'h81, 8'h01, 3'd6, 1);
    run_op("shr_f0_7", 3'd6, 8'hF0, 8'h07, 3'd7, 1);
    run_op("and", 3'd2, 8'hCC, 8'hAA, 3'd0, 1);
    run_op("or", 3'd3, 8'h0C, 8'hA0, 3'd1, 1);
    run_op("xor", 3'd4, 8'hFF, 8'hFF, 3'd2, 1);
    run_op("sub_eq", 3'd1, 8'h40, 8'h40, 3'd3, 1);
  endtask

`ifdef ULA_MUL_EN
  task automatic test_mul();
    run_op("mul_0d_0b", 3'd7, 8'h0D, 8'h0B, 3'd5, 9);
    run_op("mul_20_10", 3'd7, 8'h20, 8'h10, 3'd6, 9);
    run_op("mul_ff_ff", 3'd7, 8'hFF, 8'hFF, 3'd7, 9);
  endtask
`else
  task automatic test_mov();
    run_op("mov_5a", 3'd7, 8'h5A, 8'h33, 3'd4, 1);
    run_op("mov_80", 3'd7, 8'h80, 8'h01, 3'd2, 1);
  endtask
`endif

  // Reset mid-operation must abort it without any write pulse.
  task automatic test_abort();
    int w0;
    @(negedge clock);
    reg_dest = 3'd2; in_valido = 1'b1;
`ifdef ULA_MUL_EN
    op = 3'd7; dado_a = 8'h0D; dado_b = 8'h0B;
    @(posedge clock);
    #1 in_valido = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
`else
    op = 3'd0; dado_a = 8'h11; dado_b = 8'h22;
    @(posedge clock);
    #1 in_valido = 1'b0;
    #1 reset = 1'b0;
`endif
    w0 = writes;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (in_pronto !== 1'b1 || escrita !== 1'b0) begin
        failures++; $display("FAIL abort_idle got in_pronto=%b escrita=%b expected 1 0", in_pronto, escrita);
      end
    end
    checks++; if (esc_dado !== 8'h00 || flags !== 3'b000 || reg_esc !== 3'd0) begin
      failures++; $display("FAIL abort_outputs got dado=%02h flags=%03b reg=%0d expected 00 000 0", esc_dado, flags, reg_esc);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (writes != w0) begin failures++; $display("FAIL abort_no_write got %0d writes expected 0", writes - w0); end
    run_op("add_after_abort", 3'd0, 8'h12, 8'h34, 3'd3, 1);
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = writes;
    @(negedge clock);
    op = 3'd0; dado_a = 8'h10; dado_b = 8'h22; reg_dest = 3'd1; in_valido = 1'b1;
    sb_q.push_back(model(3'd0, 8'h10, 8'h22, 3'd1));
    @(posedge clock);
    #1 op = 3'd3; dado_a = 8'h0F; dado_b = 8'hF0; reg_dest = 3'd6;
    @(negedge clock);
    checks++; if (in_pronto !== 1'b0) begin failures++; $display("FAIL b2b_busy got in_pronto=%b expected 0", in_pronto); end
    dado_a = 8'hA0; dado_b = 8'h05; reg_dest = 3'd7;
    sb_q.push_back(model(3'd3, 8'hA0, 8'h05, 3'd7));
    @(posedge clock);
    @(negedge clock);
    checks++; if (in_pronto !== 1'b1) begin failures++; $display("FAIL b2b_ready got in_pronto=%b expected 1", in_pronto); end
    @(posedge clock);
    #1 in_valido = 1'b0; dado_a = 8'hFF; dado_b = 8'hFF; reg_dest = 3'd0;
    @(negedge clock);
    checks++; if (escrita !== 1'b1) begin failures++; $display("FAIL b2b_second_pulse got escrita=%b expected 1", escrita); end
    repeat (4) @(negedge clock);
    checks++; if (writes - w0 != 2) begin failures++; $display("FAIL b2b_pulse_count got %0d expected 2", writes - w0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
`ifdef ULA_MUL_EN
    test_mul();
`else
    test_mov();
`endif
    test_abort();
    test_back_to_back();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
